// File: rtl/satsub8_serial.sv
// Bit-serial signed saturating subtractor: s = sat(a - b), one bit per clock via a single full-adder slice.
// Define SATSUB_OVF_FLAG_EN to add the registered ovf output (1 when the result was clamped).
module satsub8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s
`ifdef SATSUB_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] SAT   = 2'd2;

  localparam logic signed [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic                    carry;
  logic [WIDTH-1:0]        opa_p0;
  logic [WIDTH-1:0]        opb_p0;
  logic signed [WIDTH-1:0] res_p0;
  logic                    sign_a_p0;
  logic                    sign_b_p0;
  logic                    sum;
  logic                    cout;

  // Differing operand signs plus a result sign that disagrees with a means the true difference left the range.
  function automatic logic ovf_det(input logic rmsb, input logic sa, input logic sb);
    return (sa != sb) && (rmsb != sa);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_val(input logic signed [WIDTH-1:0] r,
                                                      input logic sa, input logic sb);
    if (ovf_det(r[WIDTH-1], sa, sb))
      return sa ? MINV : MAXV;
    return r;
  endfunction

  assign sum  = opa_p0[0] ^ opb_p0[0] ^ carry;
  assign cout = (opa_p0[0] & opb_p0[0]) | (opa_p0[0] & carry) | (opb_p0[0] & carry);
  assign busy = (state != IDLE);

  // Control and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
`ifdef SATSUB_OVF_FLAG_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            carry <= 1'b1;
            cnt   <= '0;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          carry <= cout;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(WIDTH-1))
            state <= SAT;
        end
        SAT: begin
          s     <= sat_val(res_p0, sign_a_p0, sign_b_p0);
`ifdef SATSUB_OVF_FLAG_EN
          ovf   <= ovf_det(res_p0[WIDTH-1], sign_a_p0, sign_b_p0);
`endif
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and partial-result shift registers; the ~b with carry-in 1 turns the adder into a subtractor.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      opa_p0    <= a;
      opb_p0    <= ~b;
      sign_a_p0 <= a[WIDTH-1];
      sign_b_p0 <= b[WIDTH-1];
    end else if (state == SHIFT) begin
      opa_p0 <= {1'b0, opa_p0[WIDTH-1:1]};
      opb_p0 <= {1'b0, opb_p0[WIDTH-1:1]};
      res_p0 <= {sum, res_p0[WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_satsub8_serial.sv
// Directed self-checking bench for satsub8_serial (WIDTH=8): latency, saturation corners, start-while-busy, reset abort, grid sweep.
module tb_satsub8_serial;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] s;
`ifdef SATSUB_OVF_FLAG_EN
  logic         ovf;
`endif

  int total  = 0;
  int passed = 0;
  int failed = 0;

  satsub8_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s)
`ifdef SATSUB_OVF_FLAG_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    if (d > 127) return 8'h7F;
    if (d < -128) return 8'h80;
    return d[W-1:0];
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    return (d > 127) || (d < -128);
  endfunction

  // Drives one request (cycle 0) and observes cycles 1..W+4 at the falling edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        output logic [W-1:0] got, output logic gov,
                        output int ndone, output int first_done, output bit busy_ok);
    @(negedge clk);
    a = ta; b = tb_; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; first_done = -1; busy_ok = 1'b1; got = 'x; gov = 1'bx;
    for (int k = 1; k <= W + 4; k++) begin
      if (k > 1) @(negedge clk);
      if (busy !== (k <= W + 1)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first_done < 0) begin
          first_done = k;
          got = s;
`ifdef SATSUB_OVF_FLAG_EN
          gov = ovf;
`else
          gov = 1'b0;
`endif
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] got, s1, s2;
    logic         gov;
    int           nd, fd, sd;
    bit           bok;
    logic [W-1:0] vals [28];

    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_s", 32'(s), 32'h00);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
`ifdef SATSUB_OVF_FLAG_EN
    chk("reset_ovf", 32'(ovf), 32'd0);
`endif
    reset = 1'b0;

    run_op(8'h05, 8'h03, got, gov, nd, fd, bok);
    chk("basic_s", 32'(got), 32'h02);
    chk("basic_busy_window", 32'(bok), 32'd1);
    chk("basic_done_cycle", 32'(fd), 32'd10);
    chk("basic_done_count", 32'(nd), 32'd1);
`ifdef SATSUB_OVF_FLAG_EN
    chk("basic_ovf", 32'(gov), 32'd0);
`endif

    run_op(8'h7F, 8'hFF, got, gov, nd, fd, bok);
    chk("pos_sat_7f_ff", 32'(got), 32'h7F);
`ifdef SATSUB_OVF_FLAG_EN
    chk("ovf_7f_ff", 32'(gov), 32'd1);
`endif
    run_op(8'h00, 8'h80, got, gov, nd, fd, bok);
    chk("pos_sat_00_80", 32'(got), 32'h7F);
`ifdef SATSUB_OVF_FLAG_EN
    chk("ovf_00_80", 32'(gov), 32'd1);
`endif
    run_op(8'h80, 8'h01, got, gov, nd, fd, bok);
    chk("neg_sat_80_01", 32'(got), 32'h80);
`ifdef SATSUB_OVF_FLAG_EN
    chk("ovf_80_01", 32'(gov), 32'd1);
`endif
    run_op(8'h80, 8'h80, got, gov, nd, fd, bok);
    chk("equal_80_80", 32'(got), 32'h00);
    chk("equal_busy_window", 32'(bok), 32'd1);
`ifdef SATSUB_OVF_FLAG_EN
    chk("ovf_80_80", 32'(gov), 32'd0);
`endif

    // Start ignored while busy, then start accepted in the done cycle.
    @(negedge clk);
    a = 8'h10; b = 8'h01; start = 1'b1;
    nd = 0; fd = -1; sd = -1; s1 = '0; s2 = '0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        nd++;
        if (fd < 0) begin fd = k; s1 = s; end
        else if (sd < 0) begin sd = k; s2 = s; end
      end
      start = (k == 4) || (k == 10);
      if (k == 4) begin a = 8'h55; b = 8'h22; end
      if (k == 10) begin a = 8'h05; b = 8'h03; end
    end
    chk("busy_start_done_cycle", 32'(fd), 32'd10);
    chk("busy_start_s", 32'(s1), 32'h0F);
    chk("b2b_done_cycle", 32'(sd), 32'd20);
    chk("b2b_s", 32'(s2), 32'h02);
    chk("b2b_done_count", 32'(nd), 32'd2);

    // Reset in cycle 4 aborts the op.
    @(negedge clk);
    a = 8'h40; b = 8'hC0; start = 1'b1;
    nd = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 4) chk("abort_busy_before", 32'(busy), 32'd1);
      if (k == 5) begin
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_s", 32'(s), 32'h00);
      end
      if (done === 1'b1) nd++;
      reset = (k == 4);
    end
    chk("abort_no_done", 32'(nd), 32'd0);

    // Grid sweep: stride-13 values plus the sign/range corners.
    for (int i = 0; i < 20; i++) vals[i] = 8'(i * 13);
    vals[20] = 8'h01; vals[21] = 8'h7F; vals[22] = 8'h80; vals[23] = 8'h81;
    vals[24] = 8'hFF; vals[25] = 8'h40; vals[26] = 8'hC0; vals[27] = 8'h7E;
    for (int i = 0; i < 28; i++) begin
      for (int j = 0; j < 28; j++) begin
        run_op(vals[i], vals[j], got, gov, nd, fd, bok);
        chk($sformatf("sweep_s_%02h_%02h", vals[i], vals[j]), 32'(got), 32'(ref_sub(vals[i], vals[j])));
        chk($sformatf("sweep_done_%02h_%02h", vals[i], vals[j]), 32'(nd), 32'd1);
`ifdef SATSUB_OVF_FLAG_EN
        chk($sformatf("sweep_ovf_%02h_%02h", vals[i], vals[j]), 32'(gov), 32'(ref_ovf(vals[i], vals[j])));
`endif
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
